dm_hart_array_ctrl: RTL and testbench

// Per-hart halt/resume/reset-tracking controller for the debug module, generalised to N harts

---
 rtl/dm_hart_array_ctrl_pkg.sv | 34 +++
 rtl/dm_hart_fsm.sv | 150 +++++++++++++++
 rtl/dm_hart_array_ctrl.sv | 108 ++++++++++
 tb/tb_dm_hart_array_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_hart_array_ctrl_pkg.sv
// Shared types for the debug-module hart-array halt/resume controller.
package dm_hart_array_ctrl_pkg;

    // Width of hartsel as carried by dmcontrol (hartsello + hartselhi).
    localparam int unsigned HartSelLen = 20;

    // Per-hart run-control state.
    typedef enum logic [1:0] {
        HART_RUNNING  = 2'd0,
        HART_HALTREQ  = 2'd1,
        HART_HALTED   = 2'd2,
        HART_RESUMING = 2'd3
    } hart_state_e;

    // dmstatus summary bits over the selected harts.
    typedef struct packed {
        logic anyhalted;
        logic allhalted;
        logic anyrunning;
        logic allrunning;
        logic anyresumeack;
        logic allresumeack;
        logic anyhavereset;
        logic allhavereset;
        logic anyunavail;
        logic allunavail;
    } dm_hart_status_t;

    // Resume-ack counter width; a disabled timeout still needs a 1-bit counter.
    function automatic int unsigned timeout_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dm_hart_fsm.sv
// Run-control state machine for one hart: halt request, halted, resume with ack timeout,
// plus the havereset / haltonreset bookkeeping for that hart.
module dm_hart_fsm
    import dm_hart_array_ctrl_pkg::*;
#(
    parameter int unsigned ResumeTimeout = 1023
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmactive_i,
    input  logic        sel_i,
    input  logic        haltreq_i,
    input  logic        resumereq_i,
    input  logic        ackhavereset_i,
    input  logic        setresethaltreq_i,
    input  logic        clrresethaltreq_i,
    input  logic        hart_reset_i,
    input  logic        unavailable_i,
    input  logic        halted_i,
    input  logic        resuming_i,
    output hart_state_e state_o,
    output logic        debug_req_o,
    output logic        resumereq_o,
    output logic        resumeack_o,
    output logic        havereset_o,
    output logic        resume_timeout_o
);

    localparam int unsigned CntW = timeout_cnt_w(ResumeTimeout);
    localparam logic [CntW-1:0] CntMax = CntW'(ResumeTimeout);

    hart_state_e     state_reg, state_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic            halted_prev_reg;
    logic            reset_halt_reg, reset_halt_next;
    logic            haltonreset_reg, haltonreset_next;
    logic            havereset_reg, havereset_next;
    logic            resumeack_reg, resumeack_next;
    logic            timeout_reg, timeout_next;

    // Requests only reach a hart that is selected and powered.
    logic sel_req, halted_rise, resume_go, timeout_hit;
    assign sel_req     = sel_i & ~unavailable_i;
    assign halted_rise = halted_i & ~halted_prev_reg;
    assign resume_go   = sel_req & resumereq_i & ~haltreq_i;
    assign timeout_hit = (ResumeTimeout != 0) && (cnt_reg == CntMax);

    // State register; dmactive low clears everything except havereset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= HART_RUNNING;
            cnt_reg         <= '0;
            halted_prev_reg <= 1'b0;
            reset_halt_reg  <= 1'b0;
            haltonreset_reg <= 1'b0;
            havereset_reg   <= 1'b1;
            resumeack_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
        end else if (!dmactive_i) begin
            state_reg       <= HART_RUNNING;
            cnt_reg         <= '0;
            halted_prev_reg <= 1'b0;
            reset_halt_reg  <= 1'b0;
            haltonreset_reg <= 1'b0;
            resumeack_reg   <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            halted_prev_reg <= halted_i;
            reset_halt_reg  <= reset_halt_next;
            haltonreset_reg <= haltonreset_next;
            havereset_reg   <= havereset_next;
            resumeack_reg   <= resumeack_next;
            timeout_reg     <= timeout_next;
        end
    end

    // Next-state logic; a hart reset overrides whatever the FSM was doing.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = '0;
        reset_halt_next  = reset_halt_reg;
        haltonreset_next = haltonreset_reg;
        havereset_next   = havereset_reg;
        resumeack_next   = resumeack_reg;
        timeout_next     = timeout_reg;

        // Clear wins over set when both arrive together.
        if (sel_req && setresethaltreq_i) haltonreset_next = 1'b1;
        if (sel_req && clrresethaltreq_i) haltonreset_next = 1'b0;
        if (sel_req && ackhavereset_i)    havereset_next   = 1'b0;

        unique case (state_reg)
            HART_RUNNING: begin
                if (halted_rise) begin
                    state_next = HART_HALTED;
                end else if (sel_req && haltreq_i) begin
                    state_next = HART_HALTREQ;
                end
            end
            HART_HALTREQ: begin
                if (halted_i) begin
                    state_next      = HART_HALTED;
                    reset_halt_next = 1'b0;
                end else if (!haltreq_i && !reset_halt_reg) begin
                    state_next = HART_RUNNING;
                end
            end
            HART_HALTED: begin
                if (resume_go) begin
                    state_next     = HART_RESUMING;
                    resumeack_next = 1'b0;
                    timeout_next   = 1'b0;
                end
            end
            HART_RESUMING: begin
                if (resuming_i) begin
                    state_next     = HART_RUNNING;
                    resumeack_next = 1'b1;
                end else if (resume_go) begin
                    // A fresh resume request restarts the ack wait.
                    timeout_next = 1'b0;
                end else begin
                    cnt_next = timeout_hit ? cnt_reg : cnt_reg + 1'b1;
                    if (timeout_hit) timeout_next = 1'b1;
                end
            end
            default: state_next = HART_RUNNING;
        endcase

        if (hart_reset_i) begin
            havereset_next  = 1'b1;
            reset_halt_next = haltonreset_reg;
            cnt_next        = '0;
            state_next      = haltonreset_reg ? HART_HALTREQ : HART_RUNNING;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        state_o          = state_reg;
        debug_req_o      = (state_reg == HART_HALTREQ);
        resumereq_o      = (state_reg == HART_RESUMING);
        resumeack_o      = resumeack_reg;
        havereset_o      = havereset_reg;
        resume_timeout_o = timeout_reg;
    end

endmodule

// File: rtl/dm_hart_array_ctrl.sv
// Hart-array halt/resume controller: builds the hart selection mask, runs one
// dm_hart_fsm per hart and reduces per-hart status into dmstatus summary bits.
module dm_hart_array_ctrl #(
    parameter int unsigned NrHarts       = 4,
    parameter int unsigned HartSelLen    = dm_hart_array_ctrl_pkg::HartSelLen,
    parameter int unsigned ResumeTimeout = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic [HartSelLen-1:0] hartsel_i,
    input  logic                  hasel_i,
    input  logic [NrHarts-1:0]    hawindow_i,
    input  logic                  haltreq_i,
    input  logic                  resumereq_i,
    input  logic                  ackhavereset_i,
    input  logic                  setresethaltreq_i,
    input  logic                  clrresethaltreq_i,
    input  logic [NrHarts-1:0]    hart_reset_i,
    input  logic [NrHarts-1:0]    unavailable_i,
    input  logic [NrHarts-1:0]    halted_i,
    input  logic [NrHarts-1:0]    resuming_i,
    output logic [NrHarts-1:0]    debug_req_o,
    output logic [NrHarts-1:0]    resumereq_o,
    output logic [NrHarts-1:0]    sel_o,
    output logic                  nonexistent_o,
    output logic                  anyhalted_o,
    output logic                  allhalted_o,
    output logic                  anyrunning_o,
    output logic                  allrunning_o,
    output logic                  anyresumeack_o,
    output logic                  allresumeack_o,
    output logic                  anyhavereset_o,
    output logic                  allhavereset_o,
    output logic                  anyunavail_o,
    output logic                  allunavail_o,
    output logic [NrHarts-1:0]    resume_timeout_o
);

    import dm_hart_array_ctrl_pkg::*;

    logic [NrHarts-1:0] sel;
    logic [NrHarts-1:0] halted_vec, running_vec, resumeack_vec, havereset_vec;
    hart_state_e        hart_state [NrHarts];
    dm_hart_status_t    status;

    for (genvar gi = 0; gi < NrHarts; gi++) begin : g_hart
        assign sel[gi] = (hartsel_i == HartSelLen'(gi)) | (hasel_i & hawindow_i[gi]);

        dm_hart_fsm #(
            .ResumeTimeout (ResumeTimeout)
        ) u_fsm (
            .clk_i             (clk_i),
            .rst_ni            (rst_ni),
            .dmactive_i        (dmactive_i),
            .sel_i             (sel[gi]),
            .haltreq_i         (haltreq_i),
            .resumereq_i       (resumereq_i),
            .ackhavereset_i    (ackhavereset_i),
            .setresethaltreq_i (setresethaltreq_i),
            .clrresethaltreq_i (clrresethaltreq_i),
            .hart_reset_i      (hart_reset_i[gi]),
            .unavailable_i     (unavailable_i[gi]),
            .halted_i          (halted_i[gi]),
            .resuming_i        (resuming_i[gi]),
            .state_o           (hart_state[gi]),
            .debug_req_o       (debug_req_o[gi]),
            .resumereq_o       (resumereq_o[gi]),
            .resumeack_o       (resumeack_vec[gi]),
            .havereset_o       (havereset_vec[gi]),
            .resume_timeout_o  (resume_timeout_o[gi])
        );

        // A resuming hart still counts as halted until it acknowledges.
        assign halted_vec[gi]  = ~unavailable_i[gi] &
                                 ((hart_state[gi] == HART_HALTED) || (hart_state[gi] == HART_RESUMING));
        assign running_vec[gi] = ~unavailable_i[gi] &
                                 ((hart_state[gi] == HART_RUNNING) || (hart_state[gi] == HART_HALTREQ));
    end

    // Summary reduction over the selected harts; all* bits need a non-empty selection.
    always_comb begin
        status.anyhalted    = |(halted_vec & sel);
        status.allhalted    = (|sel) & (&(halted_vec | ~sel));
        status.anyrunning   = |(running_vec & sel);
        status.allrunning   = (|sel) & (&(running_vec | ~sel));
        status.anyresumeack = |(resumeack_vec & sel);
        status.allresumeack = (|sel) & (&(resumeack_vec | ~sel));
        status.anyhavereset = |(havereset_vec & sel);
        status.allhavereset = (|sel) & (&(havereset_vec | ~sel));
        status.anyunavail   = |(unavailable_i & sel);
        status.allunavail   = (|sel) & (&(unavailable_i | ~sel));
    end

    assign sel_o          = sel;
    assign nonexistent_o  = (hartsel_i >= HartSelLen'(NrHarts)) && !(|sel);
    assign anyhalted_o    = status.anyhalted;
    assign allhalted_o    = status.allhalted;
    assign anyrunning_o   = status.anyrunning;
    assign allrunning_o   = status.allrunning;
    assign anyresumeack_o = status.anyresumeack;
    assign allresumeack_o = status.allresumeack;
    assign anyhavereset_o = status.anyhavereset;
    assign allhavereset_o = status.allhavereset;
    assign anyunavail_o   = status.anyunavail;
    assign allunavail_o   = status.allunavail;

endmodule

// File: tb/tb_dm_hart_array_ctrl.sv
// Directed bench for dm_hart_array_ctrl: selection table plus run-control sequences.
module tb_dm_hart_array_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic [19:0] hartsel_i;
    logic        hasel_i;
    logic [3:0]  hawindow_i;
    logic        haltreq_i, resumereq_i, ackhavereset_i;
    logic        setresethaltreq_i, clrresethaltreq_i;
    logic [3:0]  hart_reset_i, unavailable_i, halted_i, resuming_i;
    logic [3:0]  debug_req_o, resumereq_o, sel_o, resume_timeout_o;
    logic        nonexistent_o;
    logic        anyhalted_o, allhalted_o, anyrunning_o, allrunning_o;
    logic        anyresumeack_o, allresumeack_o, anyhavereset_o, allhavereset_o;
    logic        anyunavail_o, allunavail_o;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    dm_hart_array_ctrl #(
        .NrHarts       (4),
        .HartSelLen    (20),
        .ResumeTimeout (8)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .dmactive_i        (dmactive_i),
        .hartsel_i         (hartsel_i),
        .hasel_i           (hasel_i),
        .hawindow_i        (hawindow_i),
        .haltreq_i         (haltreq_i),
        .resumereq_i       (resumereq_i),
        .ackhavereset_i    (ackhavereset_i),
        .setresethaltreq_i (setresethaltreq_i),
        .clrresethaltreq_i (clrresethaltreq_i),
        .hart_reset_i      (hart_reset_i),
        .unavailable_i     (unavailable_i),
        .halted_i          (halted_i),
        .resuming_i        (resuming_i),
        .debug_req_o       (debug_req_o),
        .resumereq_o       (resumereq_o),
        .sel_o             (sel_o),
        .nonexistent_o     (nonexistent_o),
        .anyhalted_o       (anyhalted_o),
        .allhalted_o       (allhalted_o),
        .anyrunning_o      (anyrunning_o),
        .allrunning_o      (allrunning_o),
        .anyresumeack_o    (anyresumeack_o),
        .allresumeack_o    (allresumeack_o),
        .anyhavereset_o    (anyhavereset_o),
        .allhavereset_o    (allhavereset_o),
        .anyunavail_o      (anyunavail_o),
        .allunavail_o      (allunavail_o),
        .resume_timeout_o  (resume_timeout_o)
    );

    typedef struct {
        logic [19:0] hartsel;
        logic        hasel;
        logic [3:0]  hawindow;
        logic [3:0]  unavail;
        logic [3:0]  exp_sel;
        logic        exp_nonexist;
        logic        exp_allrun;
        logic        exp_anyun;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; dmactive_i = 1'b1;
        hartsel_i = '0; hasel_i = 1'b0; hawindow_i = '0;
        haltreq_i = 1'b0; resumereq_i = 1'b0; ackhavereset_i = 1'b0;
        setresethaltreq_i = 1'b0; clrresethaltreq_i = 1'b0;
        hart_reset_i = '0; unavailable_i = '0; halted_i = '0; resuming_i = '0;

        vecs[0] = '{20'd0,       1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{20'd2,       1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{20'd7,       1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{20'd7,       1'b1, 4'b1010, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{20'd0,       1'b1, 4'b1011, 4'b0000, 4'b1011, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{20'd3,       1'b0, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{20'd1,       1'b1, 4'b1100, 4'b0100, 4'b1110, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{20'hFFFFF,   1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};

        step(); step();
        rst_ni = 1'b1;
        step();

        // Reset state
        chk("rst_debug_req", 32'(debug_req_o), 32'h0);
        chk("rst_resumereq", 32'(resumereq_o), 32'h0);
        chk("rst_timeout", 32'(resume_timeout_o), 32'h0);
        chk("rst_havereset", 32'(allhavereset_o), 32'h1);
        $display("reset: debug_req=%b resumereq=%b havereset=%b", debug_req_o, resumereq_o, allhavereset_o);

        // Selection / summary table, all harts running
        for (int i = 0; i < 8; i++) begin
            hartsel_i = vecs[i].hartsel; hasel_i = vecs[i].hasel;
            hawindow_i = vecs[i].hawindow; unavailable_i = vecs[i].unavail;
            #1;
            chk($sformatf("vec%0d_sel", i), 32'(sel_o), 32'(vecs[i].exp_sel));
            chk($sformatf("vec%0d_nonexist", i), 32'(nonexistent_o), 32'(vecs[i].exp_nonexist));
            chk($sformatf("vec%0d_allrun", i), 32'(allrunning_o), 32'(vecs[i].exp_allrun));
            chk($sformatf("vec%0d_anyun", i), 32'(anyunavail_o), 32'(vecs[i].exp_anyun));
            $display("vec %0d: hartsel=%0d hasel=%b win=%b unavail=%b -> sel=%b nonexist=%b allrun=%b anyun=%b",
                     i, hartsel_i, hasel_i, hawindow_i, unavailable_i, sel_o, nonexistent_o, allrunning_o, anyunavail_o);
        end
        hasel_i = 1'b0; hawindow_i = '0; unavailable_i = '0;
        step();

        // Halt single hart 2
        hartsel_i = 20'd2; haltreq_i = 1'b1;
        step();
        chk("halt2_req", 32'(debug_req_o), 32'h4);
        halted_i[2] = 1'b1;
        step();
        chk("halt2_req_drop", 32'(debug_req_o), 32'h0);
        chk("halt2_allhalted", 32'(allhalted_o), 32'h1);
        $display("halt hart2: debug_req=%b allhalted=%b", debug_req_o, allhalted_o);
        haltreq_i = 1'b0;
        step();

        // Hart-array halt, only harts 0 and 1 respond
        hartsel_i = 20'd0; hasel_i = 1'b1; hawindow_i = 4'b1011; haltreq_i = 1'b1;
        step();
        chk("array_req", 32'(debug_req_o), 32'hB);
        halted_i = 4'b0111;
        step();
        chk("array_anyhalted", 32'(anyhalted_o), 32'h1);
        chk("array_allhalted", 32'(allhalted_o), 32'h0);
        chk("array_req_left", 32'(debug_req_o), 32'h8);
        haltreq_i = 1'b0;
        step();
        chk("array_req_abort", 32'(debug_req_o), 32'h0);
        $display("array halt: debug_req=%b anyhalted=%b allhalted=%b", debug_req_o, anyhalted_o, allhalted_o);

        // Resume hart 1 with ack
        hasel_i = 1'b0; hawindow_i = '0; hartsel_i = 20'd1; resumereq_i = 1'b1;
        step();
        resumereq_i = 1'b0;
        chk("resume1_req", 32'(resumereq_o), 32'h2);
        step(); step();
        chk("resume1_req_held", 32'(resumereq_o), 32'h2);
        resuming_i[1] = 1'b1; halted_i[1] = 1'b0;
        step();
        resuming_i = '0;
        chk("resume1_req_drop", 32'(resumereq_o), 32'h0);
        chk("resume1_allack", 32'(allresumeack_o), 32'h1);
        $display("resume hart1: resumereq=%b allresumeack=%b", resumereq_o, allresumeack_o);

        // ebreak halt of hart 1, then resume with no ack -> timeout
        halted_i[1] = 1'b1;
        step();
        chk("ebreak_allhalted", 32'(allhalted_o), 32'h1);
        resumereq_i = 1'b1;
        step();
        resumereq_i = 1'b0;
        chk("to_ack_cleared", 32'(allresumeack_o), 32'h0);
        for (int c = 0; c < 8; c++) step();
        chk("to_not_yet", 32'(resume_timeout_o), 32'h0);
        step();
        chk("to_set", 32'(resume_timeout_o), 32'h2);
        chk("to_req_held", 32'(resumereq_o), 32'h2);
        resumereq_i = 1'b1;
        step();
        resumereq_i = 1'b0;
        chk("to_cleared", 32'(resume_timeout_o), 32'h0);
        resuming_i[1] = 1'b1; halted_i[1] = 1'b0;
        step();
        resuming_i = '0;
        chk("to_resumed", 32'(resumereq_o), 32'h0);
        $display("timeout: resume_timeout=%b resumereq=%b", resume_timeout_o, resumereq_o);

        // Halt-on-reset for hart 3, ack racing with reset
        hartsel_i = 20'd3; ackhavereset_i = 1'b1;
        step();
        ackhavereset_i = 1'b0;
        chk("hor_acked", 32'(allhavereset_o), 32'h0);
        setresethaltreq_i = 1'b1;
        step();
        setresethaltreq_i = 1'b0;
        hart_reset_i[3] = 1'b1; ackhavereset_i = 1'b1;
        step();
        hart_reset_i = '0; ackhavereset_i = 1'b0;
        chk("hor_havereset", 32'(allhavereset_o), 32'h1);
        chk("hor_req", 32'(debug_req_o), 32'h8);
        step(); step();
        chk("hor_req_persist", 32'(debug_req_o), 32'h8);
        halted_i[3] = 1'b1;
        step();
        chk("hor_req_drop", 32'(debug_req_o), 32'h0);
        chk("hor_allhalted", 32'(allhalted_o), 32'h1);
        $display("haltonreset hart3: havereset=%b debug_req=%b", allhavereset_o, debug_req_o);

        // Nonexistent hart
        hartsel_i = 20'd7; hasel_i = 1'b0;
        #1;
        chk("nx_flag", 32'(nonexistent_o), 32'h1);
        chk("nx_allhalted", 32'(allhalted_o), 32'h0);
        chk("nx_allrunning", 32'(allrunning_o), 32'h0);
        $display("nonexistent: flag=%b allhalted=%b allrunning=%b", nonexistent_o, allhalted_o, allrunning_o);

        // haltreq and resumereq together: resume ignored (hart 0 is halted)
        hartsel_i = 20'd0; haltreq_i = 1'b1; resumereq_i = 1'b1;
        step();
        haltreq_i = 1'b0; resumereq_i = 1'b0;
        chk("both_no_resume", 32'(resumereq_o), 32'h0);

        // Async reset while resuming
        resumereq_i = 1'b1;
        step();
        resumereq_i = 1'b0;
        chk("mid_resume_req", 32'(resumereq_o), 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_debug_req", 32'(debug_req_o), 32'h0);
        chk("arst_resumereq", 32'(resumereq_o), 32'h0);
        chk("arst_timeout", 32'(resume_timeout_o), 32'h0);
        $display("async reset: debug_req=%b resumereq=%b timeout=%b", debug_req_o, resumereq_o, resume_timeout_o);
        step();
        rst_ni = 1'b1;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
